// File: rtl/register_dump_ctrl.sv
// -----------------------------------------------------------------------------
// register_dump_ctrl
//
// Streams the whole register bank out through a byte-wide transmitter. On
// request it halts the pipeline, takes over read port A of the bank, reads
// registers 0..N_REGS-1 in order and sends each one LSB byte first over a
// valid/ready byte interface. Read port A goes back to the pipeline when the
// dump finishes or is aborted. The block never touches the bank write port.
//
// Parameters
//   NB_DATA : register bank data width (a multiple of 8, at least 16)
//   NB_REG  : register address width
//   N_REGS  : number of registers dumped, indices 0..N_REGS-1
//
// Ports
//   i_clock        in  1        clock, all state updates on the rising edge
//   i_reset        in  1        asynchronous active-low reset
//   i_start        in  1        request a full dump, sampled only in IDLE
//   i_abort        in  1        cancel a dump in progress
//   i_pipe_addr_ra in  NB_REG   pipeline read address A
//   o_addr_ra      out NB_REG   read address A to the bank (combinational mux)
//   i_data_ra      in  NB_DATA  bank read data A, combinational from o_addr_ra
//   o_tx_data      out 8        byte to transmitter
//   o_tx_valid     out 1        o_tx_data valid
//   i_tx_ready     in  1        transmitter accepts the byte this edge
//   o_halt         out 1        stall the pipeline while the dump owns port A
//   o_busy         out 1        controller is not in IDLE
//   o_done         out 1        one-cycle pulse when a dump completes
// -----------------------------------------------------------------------------
module register_dump_ctrl #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int N_REGS  = 32
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [NB_REG-1:0]  i_pipe_addr_ra,
  output logic [NB_REG-1:0]  o_addr_ra,
  input  logic [NB_DATA-1:0] i_data_ra,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_halt,
  output logic               o_busy,
  output logic               o_done
);

  localparam int N_BYTES = NB_DATA / 8;
  localparam int CNT_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(N_BYTES - 1);
  localparam logic [NB_REG-1:0] LAST_REG  = NB_REG'(N_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HALT = 3'd1,
    S_READ = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [NB_REG-1:0]    idx_q,   idx_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic [NB_DATA-1:0]   shift_q, shift_d;
  logic                 valid_q, valid_d;
  logic                 halt_q,  halt_d;
  logic                 busy_q,  busy_d;
  logic                 done_q,  done_d;

  logic                 xfer;
  logic                 last_byte;
  logic                 last_reg;

  // A byte leaves only on an edge where it is offered and accepted.
  assign xfer      = valid_q & i_tx_ready;
  assign last_byte = (cnt_q == LAST_BYTE);
  assign last_reg  = (idx_q == LAST_REG);

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    valid_d = valid_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_HALT;
        end
      end

      // Pipeline gets one cycle to see o_halt before the dump reads the bank;
      // every dump restarts from register 0.
      S_HALT: begin
        idx_d   = '0;
        state_d = S_READ;
      end

      // o_addr_ra already points at idx_q, so i_data_ra is the register value.
      S_READ: begin
        shift_d = i_data_ra;
        cnt_d   = '0;
        valid_d = 1'b1;
        state_d = S_SEND;
      end

      S_SEND: begin
        if (xfer) begin
          shift_d = {8'h00, shift_q[NB_DATA-1:8]};
          cnt_d   = cnt_q + 1'b1;
          if (last_byte) begin
            valid_d = 1'b0;
            if (last_reg) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_READ;
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase

    // Abort wins over everything, including a handshake on the same edge: the
    // offered byte is simply dropped and no completion is reported.
    if (i_abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end

    // Halt and busy are decoded from the next state so they are registered
    // yet line up exactly with the state they describe.
    halt_d = (state_d != S_IDLE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      halt_q  <= halt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Read port A belongs to the pipeline only while idle; once a dump starts the
  // address is held on the dump index so the bank output is never disturbed.
  assign o_addr_ra  = (state_q == S_IDLE) ? i_pipe_addr_ra : idx_q;

  assign o_tx_data  = shift_q[7:0];
  assign o_tx_valid = valid_q;
  assign o_halt     = halt_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_register_dump_ctrl.sv
// -----------------------------------------------------------------------------
// tb_register_dump_ctrl
//
// Scoreboard bench for register_dump_ctrl. Every dump request pushes the full
// expected byte stream (computed from the bank contents) into a queue; an
// independent monitor pops and compares on each accepted byte. The stimulus
// side covers reset, idle behaviour, a full dump with timing, backpressure,
// start-while-busy, reset and abort in the middle of a dump, and a randomized
// bank with random ready.
// -----------------------------------------------------------------------------
module tb_register_dump_ctrl;

  localparam int NB_DATA = 32;
  localparam int NB_REG  = 5;
  localparam int N_REGS  = 32;
  localparam int BUDGET  = 4000;

  logic               i_clock = 1'b0;
  logic               i_reset;
  logic               i_start;
  logic               i_abort;
  logic [NB_REG-1:0]  i_pipe_addr_ra;
  logic [NB_REG-1:0]  o_addr_ra;
  logic [NB_DATA-1:0] i_data_ra;
  logic [7:0]         o_tx_data;
  logic               o_tx_valid;
  logic               i_tx_ready;
  logic               o_halt;
  logic               o_busy;
  logic               o_done;

  logic [NB_DATA-1:0] bank [0:N_REGS-1];
  logic [7:0]         exp_q [$];

  int checks   = 0;
  int failures = 0;
  int rx_bytes = 0;

  register_dump_ctrl #(
    .NB_DATA(NB_DATA),
    .NB_REG (NB_REG),
    .N_REGS (N_REGS)
  ) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_pipe_addr_ra(i_pipe_addr_ra),
    .o_addr_ra     (o_addr_ra),
    .i_data_ra     (i_data_ra),
    .o_tx_data     (o_tx_data),
    .o_tx_valid    (o_tx_valid),
    .i_tx_ready    (i_tx_ready),
    .o_halt        (o_halt),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  always #5 i_clock = ~i_clock;

  // Combinational bank read port.
  assign i_data_ra = bank[o_addr_ra];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a dump is every register in index order, each LSB byte first.
  function automatic void push_dump();
    for (int r = 0; r < N_REGS; r++)
      for (int b = 0; b < NB_DATA / 8; b++)
        exp_q.push_back(8'(bank[r] >> (8 * b)));
  endfunction

  // Monitor: inputs change just after the rising edge, so values seen on the
  // falling edge are what the next rising edge will sample.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always @(negedge i_clock) begin
    if (i_reset && prev_stall) begin
      chk("hold_valid", 32'(o_tx_valid), 32'd1);
      chk("hold_data", 32'(o_tx_data), 32'(prev_data));
    end
    if (i_reset && o_tx_valid && i_tx_ready && !i_abort) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_byte actual=%0h required=none at %0t", o_tx_data, $time);
      end else begin
        chk("sb_byte", 32'(o_tx_data), 32'(exp_q.pop_front()));
      end
      rx_bytes++;
    end
    prev_stall = i_reset && o_tx_valid && !i_tx_ready && !i_abort;
    prev_data  = o_tx_data;
  end

  // One dump from start to completion. Negative trigger values disable the
  // corresponding event; triggers are expressed in accepted bytes so far.
  task automatic run_dump(input int stall_at, input int restart_at, input int abort_at,
                          input int reset_at, input bit rnd, input int exp_done);
    int  n, sent, stall_left, done_cnt, halt_low, done_edge;
    bit  stalled, restarted, aborted, was_reset, finished;
    n = 0; sent = 0; stall_left = 0; done_cnt = 0; halt_low = 0; done_edge = -1;
    stalled = 0; restarted = 0; aborted = 0; was_reset = 0; finished = 0;
    rx_bytes = 0;
    push_dump();
    i_start    = 1'b1;
    i_tx_ready = 1'b1;
    @(posedge i_clock); #1;
    i_start = 1'b0;
    chk("start_busy", 32'(o_busy), 32'd1);
    while (!finished && n < BUDGET) begin
      i_tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!stalled && sent == stall_at && o_tx_valid) begin
        stalled    = 1'b1;
        stall_left = 10;
      end
      if (stall_left > 0) begin
        i_tx_ready = 1'b0;
        stall_left--;
        chk("stall_data", 32'(o_tx_data), 32'h00);
        chk("stall_valid", 32'(o_tx_valid), 32'd1);
      end
      if (!restarted && sent == restart_at) begin
        restarted = 1'b1;
        i_start   = 1'b1;
      end
      if (!aborted && sent == abort_at && o_tx_valid) begin
        aborted    = 1'b1;
        i_tx_ready = 1'b1;
        i_abort    = 1'b1;
        exp_q.delete();
      end
      if (sent == reset_at && o_tx_valid) begin
        was_reset = 1'b1;
        i_start   = 1'b0;
        i_reset   = 1'b0;
        exp_q.delete();
        #1;
        chk("areset_valid", 32'(o_tx_valid), 32'd0);
        chk("areset_data", 32'(o_tx_data), 32'd0);
        chk("areset_halt", 32'(o_halt), 32'd0);
        chk("areset_busy", 32'(o_busy), 32'd0);
        chk("areset_addr", 32'(o_addr_ra), 32'(i_pipe_addr_ra));
        @(posedge i_clock); #1;
        @(posedge i_clock); #1;
        i_reset  = 1'b1;
        finished = 1'b1;
      end else begin
        if (o_tx_valid && i_tx_ready && !i_abort) sent++;
        @(posedge i_clock); #1;
        n++;
        i_abort = 1'b0;
        i_start = 1'b0;
        if (o_done) begin
          done_cnt++;
          done_edge = n;
        end
        if (aborted) begin
          chk("abort_busy", 32'(o_busy), 32'd0);
          chk("abort_halt", 32'(o_halt), 32'd0);
          chk("abort_done", 32'(o_done), 32'd0);
          finished = 1'b1;
        end else if (!o_busy) begin
          finished = 1'b1;
        end else if (!o_halt) begin
          halt_low++;
        end
      end
    end
    chk("run_terminated", 32'(finished), 32'd1);
    if (was_reset) begin
      chk("reset_bytes", 32'(rx_bytes), 32'(reset_at));
      chk("reset_busy", 32'(o_busy), 32'd0);
    end else if (aborted) begin
      chk("abort_done_cnt", 32'(done_cnt), 32'd0);
      chk("abort_bytes", 32'(rx_bytes), 32'(abort_at));
    end else begin
      chk("done_cnt", 32'(done_cnt), 32'd1);
      chk("byte_total", 32'(rx_bytes), 32'(N_REGS * NB_DATA / 8));
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      chk("halt_held", 32'(halt_low), 32'd0);
      chk("end_halt", 32'(o_halt), 32'd0);
      chk("end_done", 32'(o_done), 32'd0);
      if (exp_done >= 0) begin
        chk("done_edge", 32'(done_edge), 32'(exp_done));
        chk("idle_edge", 32'(n), 32'(exp_done + 1));
      end
    end
  endtask

  initial begin
    i_reset        = 1'b0;
    i_start        = 1'b0;
    i_abort        = 1'b0;
    i_tx_ready     = 1'b1;
    i_pipe_addr_ra = 5'b10101;
    for (int r = 0; r < N_REGS; r++) bank[r] = 32'hA500_0000 | 32'(r);

    // Reset state, before and after a clock edge.
    #2;
    chk("rst_valid", 32'(o_tx_valid), 32'd0);
    chk("rst_data", 32'(o_tx_data), 32'd0);
    chk("rst_halt", 32'(o_halt), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_addr", 32'(o_addr_ra), 32'h15);
    @(posedge i_clock); #1;
    chk("rst_edge_busy", 32'(o_busy), 32'd0);
    i_reset = 1'b1;

    // Idle: read port follows the pipeline; abort alone does nothing.
    for (int k = 0; k < 3; k++) begin
      i_pipe_addr_ra = 5'($urandom);
      #1;
      chk("idle_addr", 32'(o_addr_ra), 32'(i_pipe_addr_ra));
      @(posedge i_clock); #1;
      chk("idle_busy", 32'(o_busy), 32'd0);
    end
    i_abort = 1'b1;
    @(posedge i_clock); #1;
    i_abort = 1'b0;
    chk("idle_abort_busy", 32'(o_busy), 32'd0);
    chk("idle_abort_valid", 32'(o_tx_valid), 32'd0);

    // Full dump, ready always high.
    run_dump(-1, -1, -1, -1, 1'b0, 161);
    // Backpressure during byte 2 of register 7.
    run_dump(30, -1, -1, -1, 1'b0, 171);
    // Second start during register 3 is ignored.
    run_dump(-1, 12, -1, -1, 1'b0, 161);
    // Reset in the middle of register 7, then a clean dump from register 0.
    run_dump(-1, -1, -1, 30, 1'b0, -1);
    run_dump(-1, -1, -1, -1, 1'b0, 161);
    // Abort together with a handshake on register 5 byte 0.
    run_dump(-1, -1, 20, -1, 1'b0, -1);
    // Random bank contents and random ready.
    for (int r = 0; r < N_REGS; r++) bank[r] = $urandom;
    run_dump(-1, -1, -1, -1, 1'b1, -1);

    repeat (2) @(posedge i_clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_dump_ctrl.md
REGISTER_DUMP_CTRL -- requirements
Module: register_dump_ctrl

Interface
REQ-001 SHALL have parameter NB_DATA, default 32: register bank data width.
REQ-002 SHALL have parameter NB_REG, default 5: register address width.
REQ-003 SHALL have parameter N_REGS, default 32: number of registers dumped, indices 0..N_REGS-1.
REQ-004 SHALL have port i_clock  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_start  in  1  request a full register dump; sampled only in IDLE.
REQ-007 SHALL have port i_abort  in  1  cancel a dump in progress.
REQ-008 SHALL have port i_pipe_addr_ra  in  NB_REG  pipeline read address A.
REQ-009 SHALL have port o_addr_ra  out  NB_REG  read address A driven to bank_register.
REQ-010 SHALL have port i_data_ra  in  NB_DATA  bank_register read data A, combinational from o_addr_ra.
REQ-011 SHALL have port o_tx_data  out  8  byte to transmitter.
REQ-012 SHALL have port o_tx_valid  out  1  o_tx_data valid.
REQ-013 SHALL have port i_tx_ready  in  1  transmitter accepts byte.
REQ-014 SHALL have port o_halt  out  1  stall pipeline while dump owns the read port.
REQ-015 SHALL have port o_busy  out  1  FSM not in IDLE.
REQ-016 SHALL have port o_done  out  1  one-cycle pulse on dump completion.

Function
REQ-017 SHALL implement FSM states IDLE, HALT, READ, SEND, DONE; all outputs except o_addr_ra registered.
REQ-018 IDLE: i_start=1 -> HALT; else stay; o_addr_ra = i_pipe_addr_ra combinationally.
REQ-019 HALT: one cycle, register index cleared to 0 -> READ.
REQ-020 READ: o_addr_ra = index; on next edge capture i_data_ra into NB_DATA shift register, byte count = 0, o_tx_valid set -> SEND.
REQ-021 SEND: o_tx_data = shift[7:0], LSB byte first; byte transferred only on edge with o_tx_valid=1 and i_tx_ready=1; then shift right by 8, byte count +1.
REQ-022 o_tx_valid and o_tx_data SHALL remain stable while i_tx_ready=0; no byte dropped or duplicated; no timeout.
REQ-023 Fourth byte accepted: if index = N_REGS-1 -> DONE, o_tx_valid cleared; else index +1, o_tx_valid cleared -> READ.
REQ-024 DONE: o_done=1 for exactly one cycle -> IDLE.
REQ-025 o_halt and o_busy SHALL be 1 in HALT, READ, SEND, DONE; 0 in IDLE.
REQ-026 With i_tx_ready held 1: 4 bytes per register, 5 cycles per register; DONE entered on 161st edge after the edge sampling i_start (N_REGS=32); IDLE on 162nd.
REQ-027 i_start in any non-IDLE state SHALL be ignored; no restart, no queuing.
REQ-028 i_abort=1 in any non-IDLE state -> IDLE next edge; o_done not asserted; pending byte dropped; i_abort overrides a simultaneous handshake; ignored in IDLE.
REQ-029 Index SHALL not wrap; dump always starts at register 0.
REQ-030 Block SHALL never drive the bank write port; writes by pipeline are not blocked.

Reset
REQ-031 i_reset=0 SHALL immediately force IDLE, index 0, shift register 0, o_tx_data=0, o_tx_valid=0, o_halt=0, o_busy=0, o_done=0, regardless of clock.
REQ-032 Reset mid-dump SHALL discard progress; next i_start dumps from register 0.

Verification
REQ-033 Reset: i_reset=0, i_pipe_addr_ra=5'b10101 -> all registered outputs 0, o_addr_ra=5'b10101.
REQ-034 Full dump: bank reg[n]=32'hA50000nn, i_tx_ready=1, start pulse -> 128 bytes, first 8 = 00,00,00,A5,01,00,00,A5; o_done on edge 161; o_halt high throughout, low after.
REQ-035 Backpressure: i_tx_ready=0 for 10 cycles during byte 2 of reg 7 -> o_tx_data=8'h00, o_tx_valid=1 held; stream resumes with no loss/duplication; total 128 bytes.
REQ-036 Start while busy: second i_start during reg 3 -> ignored; exactly 128 bytes, one o_done.
REQ-037 Reset mid-dump at reg 7 byte 2 -> outputs 0 asynchronously; new start -> first byte is reg 0 byte 0 (8'h00), 128 bytes.
REQ-038 Abort with simultaneous valid&ready at reg 5 -> IDLE next edge, no o_done, o_halt=0, that byte not counted.
